// File: rtl/peg_l2_mac_tx_framer.sv
// peg_l2_mac_tx_framer
//   Wraps an upstream Ethernet frame body (DA..payload) with a 7-byte
//   preamble, SFD, optional zero padding and a CRC-32 FCS. It then enforces
//   the inter-packet gap before the next frame starts.
//
// Optional feature macro: PEG_MAC_TX_PAD_EN
//   defined   -> short bodies are padded with 0x00 up to MIN_FRAME_BYTES.
//   undefined -> no PAD state; the FCS covers the body bytes only.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   pkt_in_*             upstream byte stream (valid/ready handshake)
//   pkt_out_*            framed byte stream to the RS tx port
//
// Only PKT_DATA_W = 8 is supported.
//
// state | meaning
// IDLE  | waiting for an upstream sop; non-sop bytes are dropped
// PRE   | sending seven 0x55 preamble bytes
// SFD   | sending 0xD5, arming the CRC
// DATA  | zero-latency pass-through of the frame body
// PAD   | zero fill up to the minimum frame length (macro builds only)
// FCS   | sending the inverted CRC, LSB first
// IPG   | idle gap, counted only on cycles with pkt_out_ready=1

module peg_l2_mac_tx_framer #(
  parameter int PKT_DATA_W      = 8,
  parameter int IPG_BYTES       = 12,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pkt_in_valid,
  input  logic                  pkt_in_sop,
  input  logic                  pkt_in_eop,
  input  logic                  pkt_in_error,
  input  logic [PKT_DATA_W-1:0] pkt_in_data,
  output logic                  pkt_in_ready,
  output logic                  pkt_out_valid,
  output logic                  pkt_out_sop,
  output logic                  pkt_out_eop,
  output logic                  pkt_out_error,
  output logic [PKT_DATA_W-1:0] pkt_out_data,
  input  logic                  pkt_out_ready
);

  localparam int                SLOT_W   = 8;
  localparam logic [SLOT_W-1:0] PRE_LAST = SLOT_W'(6);
  localparam logic [SLOT_W-1:0] FCS_LAST = SLOT_W'(3);
  localparam logic [SLOT_W-1:0] IPG_LAST = SLOT_W'(IPG_BYTES - 1);
  localparam logic [31:0]       CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]       CRC_POLY = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
`ifdef PEG_MAC_TX_PAD_EN
    PAD,
`endif
    FCS,
    IPG
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;   // down-counter for PRE / FCS / IPG slots
  logic [31:0]       crc_q, crc_d;
  logic              err_q, err_d;
  logic [31:0]       fcs;

`ifdef PEG_MAC_TX_PAD_EN
  localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME_BYTES);
  logic [10:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
`endif

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs = ~crc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      crc_q   <= CRC_INIT;
      err_q   <= 1'b0;
`ifdef PEG_MAC_TX_PAD_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
`ifdef PEG_MAC_TX_PAD_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    crc_d         = crc_q;
    err_d         = err_q;
`ifdef PEG_MAC_TX_PAD_EN
    cnt_d         = cnt_q;
`endif
    pkt_in_ready  = 1'b0;
    pkt_out_valid = 1'b0;
    pkt_out_sop   = 1'b0;
    pkt_out_eop   = 1'b0;
    pkt_out_error = 1'b0;
    pkt_out_data  = '0;

    case (state_q)
      IDLE: begin
        if (pkt_in_valid) begin
          if (pkt_in_sop) begin
            state_d = PRE;
            slot_d  = PRE_LAST;
          end else begin
            // Drop stray bytes, but keep ready low while reset is held.
            pkt_in_ready = rst_n;
          end
        end
      end

      PRE: begin
        pkt_out_valid = 1'b1;
        pkt_out_data  = 8'h55;
        pkt_out_sop   = (slot_q == PRE_LAST);
        if (pkt_out_ready) begin
          if (slot_q == '0) state_d = SFD;
          else              slot_d  = slot_q - 1'b1;
        end
      end

      SFD: begin
        pkt_out_valid = 1'b1;
        pkt_out_data  = 8'hD5;
        if (pkt_out_ready) begin
          state_d = DATA;
          crc_d   = CRC_INIT;
`ifdef PEG_MAC_TX_PAD_EN
          cnt_d   = '0;
`endif
        end
      end

      DATA: begin
        pkt_in_ready  = pkt_out_ready;
        pkt_out_valid = pkt_in_valid;
        pkt_out_data  = pkt_in_data;
        if (!pkt_in_valid) begin
          err_d = 1'b1;
        end else if (pkt_out_ready) begin
          crc_d = crc32_byte(crc_q, pkt_in_data);
`ifdef PEG_MAC_TX_PAD_EN
          cnt_d = cnt_inc;
`endif
          if (pkt_in_eop) begin
            err_d  = err_q | pkt_in_error;
            slot_d = FCS_LAST;
`ifdef PEG_MAC_TX_PAD_EN
            state_d = (cnt_inc < MIN_CNT) ? PAD : FCS;
`else
            state_d = FCS;
`endif
          end
        end
      end

`ifdef PEG_MAC_TX_PAD_EN
      PAD: begin
        pkt_out_valid = 1'b1;
        pkt_out_data  = '0;
        if (pkt_out_ready) begin
          crc_d = crc32_byte(crc_q, 8'h00);
          cnt_d = cnt_inc;
          if (cnt_inc >= MIN_CNT) begin
            state_d = FCS;
            slot_d  = FCS_LAST;
          end
        end
      end
`endif

      FCS: begin
        pkt_out_valid = 1'b1;
        case (slot_q[1:0])
          2'd3:    pkt_out_data = fcs[7:0];
          2'd2:    pkt_out_data = fcs[15:8];
          2'd1:    pkt_out_data = fcs[23:16];
          default: pkt_out_data = fcs[31:24];
        endcase
        pkt_out_eop   = (slot_q == '0);
        pkt_out_error = (slot_q == '0) & err_q;
        if (pkt_out_ready) begin
          if (slot_q == '0) begin
            state_d = IPG;
            slot_d  = IPG_LAST;
          end else begin
            slot_d = slot_q - 1'b1;
          end
        end
      end

      IPG: begin
        if (pkt_out_ready) begin
          if (slot_q == '0) begin
            err_d = 1'b0;
            // Fold the IDLE sop decision into the last gap slot so a waiting
            // frame starts exactly IPG_BYTES idle slots after the previous eop.
            if (pkt_in_valid && pkt_in_sop) begin
              state_d = PRE;
              slot_d  = PRE_LAST;
            end else begin
              state_d = IDLE;
            end
          end else begin
            slot_d = slot_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_peg_l2_mac_tx_framer.sv
module tb_peg_l2_mac_tx_framer;

  localparam logic [31:0] KAT_FCS = 32'hCBF43926;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pkt_in_valid, pkt_in_sop, pkt_in_eop, pkt_in_error;
  logic [7:0] pkt_in_data;
  logic       pkt_in_ready;
  logic       pkt_out_valid, pkt_out_sop, pkt_out_eop, pkt_out_error;
  logic [7:0] pkt_out_data;
  logic       pkt_out_ready = 1'b1;

  peg_l2_mac_tx_framer #(
    .PKT_DATA_W(8), .IPG_BYTES(12), .MIN_FRAME_BYTES(60)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_in_valid(pkt_in_valid), .pkt_in_sop(pkt_in_sop), .pkt_in_eop(pkt_in_eop),
    .pkt_in_error(pkt_in_error), .pkt_in_data(pkt_in_data), .pkt_in_ready(pkt_in_ready),
    .pkt_out_valid(pkt_out_valid), .pkt_out_sop(pkt_out_sop), .pkt_out_eop(pkt_out_eop),
    .pkt_out_error(pkt_out_error), .pkt_out_data(pkt_out_data), .pkt_out_ready(pkt_out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-ready pattern: 0 = always high, 1 = toggle 1,0,1,0...
  int rdy_mode = 0;
  always begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) pkt_out_ready = ~pkt_out_ready;
    else               pkt_out_ready = 1'b1;
  end

  // Output capture monitor.
  typedef struct {
    logic [7:0] d;
    logic       sop, eop, err;
  } xfer_t;
  xfer_t cap[$];
  int eop_count = 0, sop_cyc = 0, gap_cnt = 0, gap_last = -1;
  bit in_gap = 0;
  int hold_cnt = 0, hold_bad = 0;
  bit hold_pending = 0;
  logic [7:0] h_d;
  logic h_sop, h_eop, h_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 0;
    end else begin
      if (hold_pending) begin
        hold_cnt++;
        if (!(pkt_out_valid && pkt_out_data == h_d && pkt_out_sop == h_sop &&
              pkt_out_eop == h_eop && pkt_out_error == h_err))
          hold_bad++;
      end
      hold_pending = pkt_out_valid && !pkt_out_ready;
      h_d = pkt_out_data; h_sop = pkt_out_sop; h_eop = pkt_out_eop; h_err = pkt_out_error;
      if (pkt_out_valid && pkt_out_ready) begin
        xfer_t c;
        c.d = pkt_out_data; c.sop = pkt_out_sop; c.eop = pkt_out_eop; c.err = pkt_out_error;
        cap.push_back(c);
        if (pkt_out_sop) begin
          sop_cyc  = cyc;
          gap_last = gap_cnt;
          in_gap   = 0;
        end
        if (pkt_out_eop) begin
          eop_count++;
          in_gap  = 1;
          gap_cnt = 0;
        end
      end else if (in_gap && !pkt_out_valid && pkt_out_ready) begin
        gap_cnt++;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic send_frame(input int len, input int hole_at, input int hole_len, input bit in_err);
    int i = 0;
    int guard = 0;
    bit hole_done = 0;
    bit take;
    while (i < len) begin
      if (i == hole_at && hole_len > 0 && !hole_done) begin
        pkt_in_valid = 1'b0;
        for (int h = 0; h < hole_len; h++) begin
          @(negedge clk);
          checks++;
          if (pkt_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL underrun_valid slot %0d got %b want 0", h, pkt_out_valid);
          end
          @(posedge clk);
          #1;
        end
        hole_done = 1;
      end
      pkt_in_valid = 1'b1;
      pkt_in_data  = 8'(32'h31 + i);
      pkt_in_sop   = (i == 0);
      pkt_in_eop   = (i == len - 1);
      pkt_in_error = in_err && (i == len - 1);
      @(negedge clk);
      take = pkt_in_ready;
      @(posedge clk);
      #1;
      if (take) i++;
      guard++;
      if (guard > 3000) begin
        checks++; errors++;
        $display("FAIL send_timeout got %0d bytes want %0d", i, len);
        break;
      end
    end
    pkt_in_valid = 1'b0; pkt_in_sop = 1'b0; pkt_in_eop = 1'b0; pkt_in_error = 1'b0;
  endtask

  task automatic wait_eops(input int target);
    int g = 0;
    while (eop_count < target && g < 3000) begin
      @(posedge clk);
      g++;
    end
    #1;
    checks++;
    if (eop_count < target) begin
      errors++;
      $display("FAIL eop_timeout got %0d eops want %0d", eop_count, target);
    end
  endtask

  task automatic check_frame(input int base, input int len, input int exp_n,
                             input bit exp_err, input bit use_kat, input string nm);
    logic [7:0] exp_b[$];
    logic [31:0] c, fcs;
    int blen, bad, first_bad, sops, first_eop, err_others;
    blen = len;
`ifdef PEG_MAC_TX_PAD_EN
    if (blen < 60) blen = 60;
`endif
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    for (int i = 0; i < blen; i++) exp_b.push_back((i < len) ? 8'(32'h31 + i) : 8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < blen; i++) begin
      c = c ^ {24'h0, exp_b[8 + i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    fcs = use_kat ? KAT_FCS : ~c;
    exp_b.push_back(fcs[7:0]);   exp_b.push_back(fcs[15:8]);
    exp_b.push_back(fcs[23:16]); exp_b.push_back(fcs[31:24]);

    checks++;
    if (cap.size() < base + exp_n) begin
      errors++;
      $display("FAIL %s_count got %0d transfers want %0d", nm, cap.size() - base, exp_n);
      return;
    end
    first_eop = -1; sops = 0; err_others = 0;
    for (int i = 0; i < exp_n; i++) begin
      if (cap[base + i].sop) sops++;
      if (cap[base + i].eop && first_eop < 0) first_eop = i;
      if (i != exp_n - 1 && cap[base + i].err) err_others++;
    end
    checks++;
    if (first_eop != exp_n - 1) begin
      errors++;
      $display("FAIL %s_eop_pos got %0d want %0d", nm, first_eop, exp_n - 1);
    end
    bad = 0; first_bad = -1;
    for (int i = 0; i < exp_n && i < exp_b.size(); i++) begin
      if (cap[base + i].d !== exp_b[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_data %0d bad bytes, first at %0d got %02h want %02h",
               nm, bad, first_bad, cap[base + first_bad].d, exp_b[first_bad]);
    end
    checks++;
    if (!(cap[base].sop && sops == 1)) begin
      errors++;
      $display("FAIL %s_sop got first=%b count=%0d want first=1 count=1", nm, cap[base].sop, sops);
    end
    checks++;
    if (cap[base + exp_n - 1].err !== exp_err || err_others != 0) begin
      errors++;
      $display("FAIL %s_error got eop_err=%b others=%0d want eop_err=%b others=0",
               nm, cap[base + exp_n - 1].err, err_others, exp_err);
    end
  endtask

  typedef struct {
    int len;
    int rdy;
    int hole_at;
    int hole_len;
    bit in_err;
    bit exp_err;
    bit use_kat;
    int exp_n;
  } vec_t;
  vec_t vt[6];

  initial begin
    int base, e0, hc0, hb0, t0;

`ifdef PEG_MAC_TX_PAD_EN
    vt[0] = '{9,  0, -1, 0, 0, 0, 0, 72};
    vt[1] = '{64, 1, -1, 0, 0, 0, 0, 76};
    vt[2] = '{20, 0,  5, 3, 0, 1, 0, 72};
    vt[3] = '{60, 0, -1, 0, 1, 1, 0, 72};
    vt[4] = '{1,  1, -1, 0, 0, 0, 0, 72};
    vt[5] = '{59, 0, -1, 0, 0, 0, 0, 72};
`else
    vt[0] = '{9,  0, -1, 0, 0, 0, 1, 21};
    vt[1] = '{64, 1, -1, 0, 0, 0, 0, 76};
    vt[2] = '{20, 0,  5, 3, 0, 1, 0, 32};
    vt[3] = '{60, 0, -1, 0, 1, 1, 0, 72};
    vt[4] = '{1,  1, -1, 0, 0, 0, 0, 13};
    vt[5] = '{59, 0, -1, 0, 0, 0, 0, 71};
`endif

    // Reset with a would-be-dropped byte presented: every output must be 0.
    rst_n = 1'b0;
    pkt_in_valid = 1'b1; pkt_in_sop = 1'b0; pkt_in_eop = 1'b0; pkt_in_error = 1'b0;
    pkt_in_data = 8'hAA;
    #3;
    checks++;
    if ({pkt_in_ready, pkt_out_valid, pkt_out_sop, pkt_out_eop, pkt_out_error, pkt_out_data} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b s=%b e=%b er=%b d=%02h want all 0",
               pkt_in_ready, pkt_out_valid, pkt_out_sop, pkt_out_eop, pkt_out_error, pkt_out_data);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Non-sop byte in IDLE is accepted and discarded.
    @(negedge clk);
    checks++;
    if (pkt_in_ready !== 1'b1 || pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop got ready=%b out_valid=%b want 1 0", pkt_in_ready, pkt_out_valid);
    end
    @(posedge clk);
    #1;
    pkt_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pkt_in_ready !== 1'b0 || pkt_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drop got ready=%b out_valid=%b want 0 0", pkt_in_ready, pkt_out_valid);
    end
    @(posedge clk);
    #1;

    for (int k = 0; k < 6; k++) begin
      rdy_mode = vt[k].rdy;
      base = cap.size(); e0 = eop_count; hc0 = hold_cnt; hb0 = hold_bad;
      send_frame(vt[k].len, vt[k].hole_at, vt[k].hole_len, vt[k].in_err);
      wait_eops(e0 + 1);
      check_frame(base, vt[k].len, vt[k].exp_n, vt[k].exp_err, vt[k].use_kat, $sformatf("vec%0d", k));
      checks++;
      if (hold_bad != hb0) begin
        errors++;
        $display("FAIL vec%0d_hold_stable got %0d unstable stalls want 0", k, hold_bad - hb0);
      end
      if (vt[k].rdy == 1) begin
        checks++;
        if (hold_cnt == hc0) begin
          errors++;
          $display("FAIL vec%0d_stalls got 0 stalled slots want >0", k);
        end
      end
      rdy_mode = 0;
      repeat (30) @(posedge clk);
      #1;
    end

    // Back-to-back frames: second sop is waiting during FCS and IPG.
    base = cap.size(); e0 = eop_count;
    send_frame(9, -1, 0, 0);
    send_frame(9, -1, 0, 0);
    wait_eops(e0 + 2);
    check_frame(base, 9, vt[0].exp_n, 0, vt[0].use_kat, "b2b_a");
    check_frame(base + vt[0].exp_n, 9, vt[0].exp_n, 0, vt[0].use_kat, "b2b_b");
    checks++;
    if (gap_last != 12) begin
      errors++;
      $display("FAIL b2b_gap got %0d idle slots want 12", gap_last);
    end
    repeat (30) @(posedge clk);
    #1;

    // Reset while the 4th preamble byte is on the bus.
    base = cap.size();
    pkt_in_valid = 1'b1; pkt_in_sop = 1'b1; pkt_in_eop = 1'b0; pkt_in_data = 8'h31;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      #1;
      if (cap.size() - base == 3) break;
    end
    checks++;
    if (cap.size() - base != 3 || pkt_out_data !== 8'h55 || pkt_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre4_reach got %0d transfers v=%b d=%02h want 3 1 55",
               cap.size() - base, pkt_out_valid, pkt_out_data);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pkt_in_ready, pkt_out_valid, pkt_out_sop, pkt_out_eop, pkt_out_error, pkt_out_data} !== 13'h0) begin
      errors++;
      $display("FAIL midpre_reset got rdy=%b v=%b d=%02h want 0 0 00",
               pkt_in_ready, pkt_out_valid, pkt_out_data);
    end
    pkt_in_valid = 1'b0; pkt_in_sop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (pkt_out_valid !== 1'b0 || cap.size() - base != 3) begin
      errors++;
      $display("FAIL no_resume got out_valid=%b transfers=%0d want 0 3", pkt_out_valid, cap.size() - base);
    end
    base = cap.size(); e0 = eop_count;
    t0 = cyc;
    send_frame(9, -1, 0, 0);
    wait_eops(e0 + 1);
    check_frame(base, 9, vt[0].exp_n, 0, vt[0].use_kat, "post_reset");
    checks++;
    if (sop_cyc - t0 != 1) begin
      errors++;
      $display("FAIL post_reset_latency got %0d cycles want 1", sop_cyc - t0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
